// File: rtl/fminmax_reduce_if.sv
// fminmax_reduce_if: command, element stream and result handshake of the min/max reducer
interface fminmax_reduce_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 8
);
  localparam int DATA_W = 1 + EXP_W + MAN_W;
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              Fmode;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result_out;
  logic [CNT_W-1:0]  result_idx;
  logic              nan_flag;
  logic              empty_flag;
  logic              busy;
  modport master (
    output start, len, Fmode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, result_out, result_idx, nan_flag, empty_flag, busy
  );
  modport slave (
    input  start, len, Fmode, in_valid, in_data, out_ready,
    output in_ready, out_valid, result_out, result_idx, nan_flag, empty_flag, busy
  );
endinterface

// File: rtl/fminmax_reduce.sv
// fminmax_reduce: streaming floating-point max/min reduction with argmax/argmin index and NaN skipping
module fminmax_reduce #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  fminmax_reduce_if.slave  bus
);
  localparam int DATA_W = 1 + EXP_W + MAN_W;
  localparam logic [DATA_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, len_q, len_d, idx_q, idx_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              mode_q, mode_d, have_q, have_d, nan_q, nan_d, empty_q, empty_d;
  logic              in_nan, better;
  // Maps sign-magnitude onto an unsigned scale: negatives flip entirely, positives set the top bit
  function automatic logic [DATA_W-1:0] key(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? ~x : {1'b1, x[DATA_W-2:0]};
  endfunction
  assign in_nan = (&bus.in_data[DATA_W-2:MAN_W]) && (|bus.in_data[MAN_W-1:0]);
  assign better = mode_q ? (key(bus.in_data) < key(acc_q)) : (key(bus.in_data) > key(acc_q));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    have_d  = have_q;
    nan_d   = nan_q;
    empty_d = empty_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = (bus.len == '0) ? DONE : ACCUM;
        len_d   = bus.len;
        mode_d  = bus.Fmode;
        cnt_d   = '0;
        idx_d   = '0;
        acc_d   = (bus.len == '0) ? QNAN : '0;
        have_d  = 1'b0;
        nan_d   = 1'b0;
        empty_d = (bus.len == '0);
      end
      ACCUM: if (bus.in_valid) begin
        cnt_d = cnt_q + 1'b1;
        if (in_nan) nan_d = 1'b1;
        else if (!have_q || better) begin
          acc_d  = bus.in_data;
          idx_d  = cnt_q;
          have_d = 1'b1;
        end
        if (cnt_q == len_q - 1'b1) begin
          state_d = DONE;
          acc_d   = have_d ? acc_d : QNAN;
          idx_d   = have_d ? idx_d : '0;
        end
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      mode_q  <= 1'b0;
      have_q  <= 1'b0;
      nan_q   <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      have_q  <= have_d;
      nan_q   <= nan_d;
      empty_q <= empty_d;
    end
  end
  assign bus.in_ready   = (state_q == ACCUM);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.result_out = acc_q;
  assign bus.result_idx = idx_q;
  assign bus.nan_flag   = nan_q;
  assign bus.empty_flag = empty_q;
endmodule

// File: tb/tb_fminmax_reduce.sv
// tb_fminmax_reduce: randomized and directed checks of fminmax_reduce against a numeric reference model
module tb_fminmax_reduce;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [31:0] vec[$];
  logic [31:0] exp_res;
  logic [7:0]  exp_idx;
  logic        exp_nan, exp_empty;
  logic [31:0] got_res;
  logic [7:0]  got_idx;
  logic        got_nan, got_empty, lat_ok;
  fminmax_reduce_if b ();
  fminmax_reduce dut (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
  endfunction
  // True numeric order: negative below positive, magnitudes reversed among negatives
  function automatic bit lt(input logic [31:0] a, input logic [31:0] c);
    if (a[31] != c[31]) return a[31];
    if (!a[31]) return a[30:0] < c[30:0];
    return a[30:0] > c[30:0];
  endfunction
  task automatic model(input bit mode);
    bit found = 0;
    exp_res = QNAN; exp_idx = 0; exp_nan = 0; exp_empty = (vec.size() == 0);
    for (int i = 0; i < vec.size(); i++) begin
      if (is_nan(vec[i])) exp_nan = 1;
      else if (!found || (mode ? lt(vec[i], exp_res) : lt(exp_res, vec[i]))) begin
        exp_res = vec[i]; exp_idx = 8'(i); found = 1;
      end
    end
  endtask
  function automatic logic [31:0] rnd_elem();
    logic [31:0] r;
    bit s = ($urandom_range(0, 1) == 1);
    case ($urandom_range(0, 7))
      0: r = 32'h0000_0000;
      1: r = 32'h8000_0000;
      2: r = {s, 8'hFF, 23'h0};
      3: r = {s, 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
      4: r = {s, 8'h00, 23'($urandom)};
      5: r = (vec.size() > 0) ? vec[$urandom_range(0, vec.size() - 1)] : $urandom;
      default: r = $urandom;
    endcase
    return r;
  endfunction
  task automatic run_vec(input bit mode, input bit gaps, input bit pulse);
    int k = 0;
    int cyc = 0;
    int n = vec.size();
    lat_ok = 1;
    @(negedge clk);
    b.start = 1; b.len = 8'(n); b.Fmode = mode;
    @(negedge clk);
    b.start = 0; b.len = 8'($urandom); b.Fmode = ~mode;
    while (k < n && cyc < 1000) begin
      b.start = pulse && ($urandom_range(0, 2) == 0);
      b.len = 8'($urandom);
      b.in_valid = !(gaps && $urandom_range(0, 2) == 0);
      b.in_data = vec[k];
      if (b.out_valid !== 1'b0 || b.in_ready !== 1'b1) lat_ok = 0;
      if (b.in_valid) k++;
      @(negedge clk);
      cyc++;
    end
    b.in_valid = 0; b.start = 0;
    if (k < n || b.out_valid !== 1'b1 || b.in_ready !== 1'b0) lat_ok = 0;
    got_res = b.result_out; got_idx = b.result_idx; got_nan = b.nan_flag; got_empty = b.empty_flag;
  endtask
  task automatic finish_vec(input bit with_start);
    b.out_ready = 1; b.start = with_start; b.len = 0;
    @(negedge clk);
    b.out_ready = 0; b.start = 0;
  endtask
  task automatic test_reset();
    #12;
    total++;
    if ({b.out_valid, b.in_ready, b.busy, b.nan_flag, b.empty_flag, b.result_out, b.result_idx} !== 45'h0) begin
      bad++;
      $display("FAIL reset_outputs: got rv=%h ri=%h busy=%b nan=%b empty=%b ov=%b required all zero",
               b.result_out, b.result_idx, b.busy, b.nan_flag, b.empty_flag, b.out_valid);
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    total++;
    if ({b.busy, b.in_ready, b.out_valid} !== 3'b000) begin
      bad++; $display("FAIL idle_after_reset: got busy=%b ready=%b ov=%b required 000", b.busy, b.in_ready, b.out_valid);
    end
  endtask
  task automatic test_max_example();
    vec = '{32'h4020_0000, 32'h4160_0000, 32'h4093_8514, 32'h4160_0000};
    run_vec(0, 0, 0);
    total++;
    if ({lat_ok, got_res, got_idx, got_nan, got_empty} !== {1'b1, 32'h4160_0000, 8'd1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL max_example: got lat=%b res=%h idx=%0d nan=%b required lat=1 res=41600000 idx=1 nan=0", lat_ok, got_res, got_idx, got_nan);
    end
    finish_vec(0);
  endtask
  task automatic test_min_zero();
    vec = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000};
    run_vec(1, 0, 0);
    total++;
    if ({lat_ok, got_res, got_idx, got_nan} !== {1'b1, 32'h8000_0000, 8'd1, 1'b0}) begin
      bad++; $display("FAIL min_neg_zero: got lat=%b res=%h idx=%0d nan=%b required lat=1 res=80000000 idx=1 nan=0", lat_ok, got_res, got_idx, got_nan);
    end
    finish_vec(0);
  endtask
  task automatic test_nan();
    vec = '{32'h7FC0_0001, 32'hC2DE_0000, 32'h7F80_0001};
    run_vec(0, 0, 0);
    total++;
    if ({lat_ok, got_res, got_idx, got_nan} !== {1'b1, 32'hC2DE_0000, 8'd1, 1'b1}) begin
      bad++; $display("FAIL nan_skip: got lat=%b res=%h idx=%0d nan=%b required lat=1 res=c2de0000 idx=1 nan=1", lat_ok, got_res, got_idx, got_nan);
    end
    finish_vec(0);
    vec = '{32'hFFFF_FFFF, 32'h7F80_0001, 32'h7FC0_0000};
    run_vec(1, 0, 0);
    total++;
    if ({lat_ok, got_res, got_idx, got_nan, got_empty} !== {1'b1, QNAN, 8'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL all_nan: got lat=%b res=%h idx=%0d nan=%b required lat=1 res=7fc00000 idx=0 nan=1", lat_ok, got_res, got_idx, got_nan);
    end
    finish_vec(0);
  endtask
  task automatic test_empty();
    vec.delete();
    run_vec(0, 0, 0);
    total++;
    if ({lat_ok, got_res, got_idx, got_nan, got_empty} !== {1'b1, QNAN, 8'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL empty_vec: got lat=%b res=%h idx=%0d nan=%b empty=%b required lat=1 res=7fc00000 idx=0 nan=0 empty=1", lat_ok, got_res, got_idx, got_nan, got_empty);
    end
    for (int c = 0; c < 5; c++) begin
      b.start = ($urandom_range(0, 1) == 1); b.len = 8'd3;
      @(negedge clk);
      total++;
      if ({b.out_valid, b.result_out, b.result_idx, b.nan_flag, b.empty_flag} !== {1'b1, QNAN, 8'd0, 1'b0, 1'b1}) begin
        bad++; $display("FAIL empty_hold%0d: got ov=%b res=%h idx=%0d nan=%b empty=%b required held DONE outputs",
                        c, b.out_valid, b.result_out, b.result_idx, b.nan_flag, b.empty_flag);
      end
    end
    finish_vec(1);
    total++;
    if ({b.busy, b.out_valid} !== 2'b00) begin
      bad++; $display("FAIL handshake_start_ignored: got busy=%b ov=%b required 00", b.busy, b.out_valid);
    end
  endtask
  task automatic test_random();
    for (int r = 0; r < 40; r++) begin
      bit mode = (r == 0) ? 1'b0 : ($urandom_range(0, 1) == 1);
      int n = (r == 0) ? 5 : $urandom_range(1, 12);
      vec.delete();
      for (int i = 0; i < n; i++) vec.push_back(rnd_elem());
      model(mode);
      run_vec(mode, 1, 1);
      total++;
      if ({lat_ok, got_res, got_idx, got_nan, got_empty} !== {1'b1, exp_res, exp_idx, exp_nan, exp_empty}) begin
        bad++; $display("FAIL random%0d mode=%0d n=%0d: got lat=%b res=%h idx=%0d nan=%b empty=%b required lat=1 res=%h idx=%0d nan=%b empty=%b",
                        r, mode, n, lat_ok, got_res, got_idx, got_nan, got_empty, exp_res, exp_idx, exp_nan, exp_empty);
      end
      finish_vec($urandom_range(0, 1) == 1);
      total++;
      if (b.busy !== 1'b0) begin
        bad++; $display("FAIL random%0d_idle: got busy=%b required 0", r, b.busy);
      end
    end
  endtask
  task automatic test_abort();
    bit saw_valid = 0;
    @(negedge clk);
    b.start = 1; b.len = 8'd5; b.Fmode = 0;
    @(negedge clk);
    b.start = 0; b.in_valid = 1; b.in_data = 32'h4120_0000;
    @(negedge clk);
    b.in_data = 32'h4140_0000;
    @(negedge clk);
    b.in_valid = 0;
    #2 rst_n = 0;
    #1;
    total++;
    if ({b.out_valid, b.in_ready, b.busy, b.nan_flag, b.empty_flag, b.result_out, b.result_idx} !== 45'h0) begin
      bad++; $display("FAIL abort_reset: got res=%h idx=%h busy=%b ready=%b ov=%b required all zero",
                      b.result_out, b.result_idx, b.busy, b.in_ready, b.out_valid);
    end
    @(negedge clk); rst_n = 1;
    for (int c = 0; c < 8; c++) begin
      b.in_valid = 1; b.in_data = $urandom;
      @(negedge clk);
      if (b.out_valid !== 1'b0 || b.busy !== 1'b0) saw_valid = 1;
    end
    b.in_valid = 0;
    total++;
    if (saw_valid || b.result_out !== 32'h0) begin
      bad++; $display("FAIL abort_no_result: got saw_valid=%b res=%h required 0 and 00000000", saw_valid, b.result_out);
    end
  endtask
  initial begin
    b.start = 0; b.len = 0; b.Fmode = 0; b.in_valid = 0; b.in_data = 0; b.out_ready = 0;
    test_reset();
    test_max_example();
    test_min_zero();
    test_nan();
    test_empty();
    test_random();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
